dec_rv_ssc_issue_sched: RTL and testbench

//  Issue scheduler for the RISC-V superscalar front end. Buffers fetched 32-bit

---
 rtl/dec_rv_ssc_issue_sched.sv | 140 ++++++++++++++
 tb/tb_dec_rv_ssc_issue_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_rv_ssc_issue_sched.sv
// Superscalar issue scheduler: buffers fetched words, forms 1..3 lane bundles
// from the register-conflict checker result, and loads a registered issue stage.
module dec_rv_ssc_issue_sched #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH_MAX = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchValid,
  input  logic [31:0] fetchWord,
  output logic        fetchReady,
  input  logic        flush,
  input  logic        sscEnable,
  output logic [31:0] chkWordA,
  output logic [31:0] chkWordB,
  output logic [31:0] chkWordC,
  input  logic [3:0]  chkFlag,
  input  logic        issueReady,
  output logic [2:0]  issueValid,
  output logic [31:0] issueWordA,
  output logic [31:0] issueWordB,
  output logic [31:0] issueWordC,
  output logic [15:0] cntMulti
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] word_a, word_b, word_c;
  logic        rv32_a, rv32_b, rv32_c;
  logic        ctrl_a, ctrl_b;
  logic        sys_a, sys_b, sys_c;
  logic [1:0]  avail;
  logic        lane_b, lane_c;
  logic [1:0]  n;
  logic [1:0]  pop;
  logic        push;
  logic        load;

  // Full flag comes from the registered count; forced low while in reset.
  assign fetchReady = reset && (count != CNT_W'(DEPTH));
  assign push       = fetchValid && fetchReady;

  assign word_a = mem[rd_ptr];
  assign word_b = mem[rd_ptr + PTR_W'(1)];
  assign word_c = mem[rd_ptr + PTR_W'(2)];

  // Oldest three entries to the checker, zero when not present.
  assign chkWordA = (count >= CNT_W'(1)) ? word_a : 32'd0;
  assign chkWordB = (count >= CNT_W'(2)) ? word_b : 32'd0;
  assign chkWordC = (count >= CNT_W'(3)) ? word_c : 32'd0;

  assign rv32_a = (word_a[1:0] == 2'b11);
  assign rv32_b = (word_b[1:0] == 2'b11);
  assign rv32_c = (word_c[1:0] == 2'b11);
  assign ctrl_a = (word_a[6:0] == OP_BRANCH) || (word_a[6:0] == OP_JAL) || (word_a[6:0] == OP_JALR);
  assign ctrl_b = (word_b[6:0] == OP_BRANCH) || (word_b[6:0] == OP_JAL) || (word_b[6:0] == OP_JALR);
  assign sys_a  = (word_a[6:0] == OP_SYSTEM);
  assign sys_b  = (word_b[6:0] == OP_SYSTEM);
  assign sys_c  = (word_c[6:0] == OP_SYSTEM);

  // Lanes available from occupancy, lane cap and superscalar enable.
  always_comb begin
    avail = 2'd0;
    if (count >= CNT_W'(3)) avail = 2'd3;
    else                    avail = 2'(count);
    if (avail > 2'(WIDTH_MAX)) avail = 2'(WIDTH_MAX);
    if (!sscEnable && (avail > 2'd1)) avail = 2'd1;
  end

  // Pairing rules: a lane joins only if every earlier lane joined.
  always_comb begin
    lane_b = (avail >= 2'd2) && (chkFlag[1:0] == 2'b00) && rv32_a && rv32_b
             && !ctrl_a && !sys_a && !sys_b;
    lane_c = lane_b && (avail == 2'd3) && (chkFlag[3:2] == 2'b00) && rv32_c
             && !ctrl_b && !sys_c;
    if (lane_c)              n = 2'd3;
    else if (lane_b)         n = 2'd2;
    else if (avail >= 2'd1)  n = 2'd1;
    else                     n = 2'd0;
  end

  assign load = !issueValid[0] || issueReady;
  assign pop  = load ? n : 2'd0;

  // Queue pointers and occupancy; flush clears everything and drops the push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= fetchWord;
  end

  // Issue stage load with thermometer valids; unused lanes carry zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issueValid <= 3'b000;
      issueWordA <= 32'd0;
      issueWordB <= 32'd0;
      issueWordC <= 32'd0;
      cntMulti   <= 16'd0;
    end else if (flush) begin
      issueValid <= 3'b000;
      issueWordA <= 32'd0;
      issueWordB <= 32'd0;
      issueWordC <= 32'd0;
    end else if (load) begin
      issueValid <= {n == 2'd3, n >= 2'd2, n >= 2'd1};
      issueWordA <= (n >= 2'd1) ? word_a : 32'd0;
      issueWordB <= (n >= 2'd2) ? word_b : 32'd0;
      issueWordC <= (n == 2'd3) ? word_c : 32'd0;
      if (n >= 2'd2) cntMulti <= cntMulti + 16'd1;
    end
  end

endmodule

// File: tb/tb_dec_rv_ssc_issue_sched.sv
// Directed bench for the issue scheduler: vector table plus hand sequences
// for back-pressure, flush and asynchronous reset.
module tb_dec_rv_ssc_issue_sched;

  logic        clock;
  logic        reset;
  logic        fetchValid;
  logic [31:0] fetchWord;
  logic        fetchReady;
  logic        flush;
  logic        sscEnable;
  logic [31:0] chkWordA, chkWordB, chkWordC;
  logic [3:0]  chkFlag;
  logic        issueReady;
  logic [2:0]  issueValid;
  logic [31:0] issueWordA, issueWordB, issueWordC;
  logic [15:0] cntMulti;

  int tests;
  int failed;

  localparam logic [31:0] W0  = 32'h00000013;
  localparam logic [31:0] W1  = 32'h00100093;
  localparam logic [31:0] W2  = 32'h00200113;
  localparam logic [31:0] W3  = 32'h00300193;
  localparam logic [31:0] W4  = 32'h00400213;
  localparam logic [31:0] W5  = 32'h00500293;
  localparam logic [31:0] JAL = 32'h0000006F;
  localparam logic [31:0] CW  = 32'h00000001;
  localparam logic [31:0] SYS = 32'h00000073;

  typedef struct {
    logic        fv;
    logic [31:0] w;
    logic        ssc;
    logic [3:0]  flag;
    logic        rdy;
    logic [2:0]  iv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] chka;
    logic [15:0] cm;
  } vec_t;

  vec_t vq[$];

  dec_rv_ssc_issue_sched #(.DEPTH(8), .WIDTH_MAX(3)) dut (
    .clock(clock), .reset(reset),
    .fetchValid(fetchValid), .fetchWord(fetchWord), .fetchReady(fetchReady),
    .flush(flush), .sscEnable(sscEnable),
    .chkWordA(chkWordA), .chkWordB(chkWordB), .chkWordC(chkWordC),
    .chkFlag(chkFlag), .issueReady(issueReady),
    .issueValid(issueValid),
    .issueWordA(issueWordA), .issueWordB(issueWordB), .issueWordC(issueWordC),
    .cntMulti(cntMulti)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic vec_t mk(input logic fv, input logic [31:0] w, input logic ssc,
                              input logic [3:0] flag, input logic rdy, input logic [2:0] iv,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] chka, input logic [15:0] cm);
    vec_t v;
    v.fv = fv; v.w = w; v.ssc = ssc; v.flag = flag; v.rdy = rdy;
    v.iv = iv; v.a = a; v.b = b; v.c = c; v.chka = chka; v.cm = cm;
    return v;
  endfunction

  function automatic logic [31:0] dw(input int i);
    return 32'h00000013 | (32'(i + 1) << 7);
  endfunction

  initial begin
    tests = 0; failed = 0;
    reset = 1'b0; fetchValid = 1'b0; fetchWord = 32'd0; flush = 1'b0;
    sscEnable = 1'b1; chkFlag = 4'd0; issueReady = 1'b1;

    //          fv  word ssc flag   rdy  iv      A    B   C   chkA  cm
    // three-wide bundle
    vq.push_back(mk(1, W0,  1, 4'h0, 1, 3'b000, 0,   0,  0,  W0,  0));
    vq.push_back(mk(1, W1,  1, 4'h0, 0, 3'b001, W0,  0,  0,  W1,  0));
    vq.push_back(mk(1, W2,  1, 4'h0, 0, 3'b001, W0,  0,  0,  W1,  0));
    vq.push_back(mk(1, W3,  1, 4'h0, 0, 3'b001, W0,  0,  0,  W1,  0));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b111, W1,  W2, W3, 0,   1));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b000, 0,   0,  0,  0,   1));
    // A/B conflict, then re-check of old B/C
    vq.push_back(mk(1, W0,  1, 4'h0, 1, 3'b000, 0,   0,  0,  W0,  1));
    vq.push_back(mk(1, W1,  1, 4'h0, 0, 3'b001, W0,  0,  0,  W1,  1));
    vq.push_back(mk(1, W2,  1, 4'h0, 0, 3'b001, W0,  0,  0,  W1,  1));
    vq.push_back(mk(1, W3,  1, 4'h0, 0, 3'b001, W0,  0,  0,  W1,  1));
    vq.push_back(mk(0, 0,   1, 4'h1, 1, 3'b001, W1,  0,  0,  W2,  1));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b011, W2,  W3, 0,  0,   2));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b000, 0,   0,  0,  0,   2));
    // control transfer in lane A
    vq.push_back(mk(1, W0,  1, 4'h0, 1, 3'b000, 0,   0,  0,  W0,  2));
    vq.push_back(mk(1, JAL, 1, 4'h0, 0, 3'b001, W0,  0,  0,  JAL, 2));
    vq.push_back(mk(1, W4,  1, 4'h0, 0, 3'b001, W0,  0,  0,  JAL, 2));
    vq.push_back(mk(1, W5,  1, 4'h0, 0, 3'b001, W0,  0,  0,  JAL, 2));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b001, JAL, 0,  0,  W4,  2));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b011, W4,  W5, 0,  0,   3));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b000, 0,   0,  0,  0,   3));
    // non-RV32 word alone, then single issue forced by sscEnable=0
    vq.push_back(mk(1, W0,  1, 4'h0, 1, 3'b000, 0,   0,  0,  W0,  3));
    vq.push_back(mk(1, CW,  1, 4'h0, 0, 3'b001, W0,  0,  0,  CW,  3));
    vq.push_back(mk(1, W1,  1, 4'h0, 0, 3'b001, W0,  0,  0,  CW,  3));
    vq.push_back(mk(1, W2,  1, 4'h0, 0, 3'b001, W0,  0,  0,  CW,  3));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b001, CW,  0,  0,  W1,  3));
    vq.push_back(mk(0, 0,   0, 4'h0, 1, 3'b001, W1,  0,  0,  W2,  3));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b001, W2,  0,  0,  0,   3));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b000, 0,   0,  0,  0,   3));
    // B/C conflict, then SYSTEM word in lane B
    vq.push_back(mk(1, W0,  1, 4'h0, 1, 3'b000, 0,   0,  0,  W0,  3));
    vq.push_back(mk(1, W1,  1, 4'h0, 0, 3'b001, W0,  0,  0,  W1,  3));
    vq.push_back(mk(1, W2,  1, 4'h0, 0, 3'b001, W0,  0,  0,  W1,  3));
    vq.push_back(mk(1, W3,  1, 4'h0, 0, 3'b001, W0,  0,  0,  W1,  3));
    vq.push_back(mk(0, 0,   1, 4'h4, 1, 3'b011, W1,  W2, 0,  W3,  4));
    vq.push_back(mk(1, SYS, 1, 4'h0, 0, 3'b011, W1,  W2, 0,  W3,  4));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b001, W3,  0,  0,  SYS, 4));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b001, SYS, 0,  0,  0,   4));
    vq.push_back(mk(0, 0,   1, 4'h0, 1, 3'b000, 0,   0,  0,  0,   4));

    // reset state
    @(negedge clock); @(negedge clock);
    chk("rst iv", 32'(issueValid), 32'd0);
    chk("rst cm", 32'(cntMulti), 32'd0);
    chk("rst fr", 32'(fetchReady), 32'd0);
    chk("rst chkA", chkWordA, 32'd0);
    reset = 1'b1;
    #1;
    chk("post-rst fr", 32'(fetchReady), 32'd1);
    @(negedge clock);

    for (int i = 0; i < vq.size(); i++) begin
      fetchValid = vq[i].fv; fetchWord = vq[i].w; sscEnable = vq[i].ssc;
      chkFlag = vq[i].flag; issueReady = vq[i].rdy;
      step();
      chk($sformatf("v%0d iv", i), 32'(issueValid), 32'(vq[i].iv));
      chk($sformatf("v%0d A", i), issueWordA, vq[i].a);
      chk($sformatf("v%0d B", i), issueWordB, vq[i].b);
      chk($sformatf("v%0d C", i), issueWordC, vq[i].c);
      chk($sformatf("v%0d chkA", i), chkWordA, vq[i].chka);
      chk($sformatf("v%0d cm", i), 32'(cntMulti), 32'(vq[i].cm));
      chk($sformatf("v%0d fr", i), 32'(fetchReady), 32'd1);
    end

    // back-pressure: fill to DEPTH with the issue stage held
    fetchValid = 1'b0; sscEnable = 1'b1; chkFlag = 4'd0;
    fetchValid = 1'b1; fetchWord = W0; issueReady = 1'b1;
    step();
    issueReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fetchWord = dw(i);
      step();
      chk($sformatf("fill%0d fr", i), 32'(fetchReady), (i < 7) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d A", i), issueWordA, W0);
    end
    fetchWord = dw(8);
    step();
    chk("full fr", 32'(fetchReady), 32'd0);
    chk("full iv", 32'(issueValid), 32'd1);
    chk("full A", issueWordA, W0);
    chk("full chkA", chkWordA, dw(0));
    fetchValid = 1'b0; issueReady = 1'b1;
    step();
    chk("drain1 iv", 32'(issueValid), 32'd7);
    chk("drain1 A", issueWordA, dw(0));
    chk("drain1 C", issueWordC, dw(2));
    chk("drain1 fr", 32'(fetchReady), 32'd1);
    step();
    chk("drain2 A", issueWordA, dw(3));
    step();
    chk("drain3 iv", 32'(issueValid), 32'd3);
    chk("drain3 A", issueWordA, dw(6));
    chk("drain3 B", issueWordB, dw(7));
    step();
    chk("drain4 iv", 32'(issueValid), 32'd0);
    chk("drain cm", 32'(cntMulti), 32'd7);

    // flush beats a simultaneous push and load
    fetchValid = 1'b1; fetchWord = W0; issueReady = 1'b1;
    step();
    fetchWord = W1; issueReady = 1'b0;
    step();
    chk("preflush iv", 32'(issueValid), 32'd1);
    flush = 1'b1; fetchWord = W2; issueReady = 1'b1;
    step();
    chk("flush iv", 32'(issueValid), 32'd0);
    chk("flush A", issueWordA, 32'd0);
    chk("flush chkA", chkWordA, 32'd0);
    chk("flush fr", 32'(fetchReady), 32'd1);
    chk("flush cm", 32'(cntMulti), 32'd7);
    flush = 1'b0; fetchValid = 1'b0;
    step();
    chk("postflush1 iv", 32'(issueValid), 32'd0);
    step();
    chk("postflush2 iv", 32'(issueValid), 32'd0);

    // asynchronous reset mid-stream
    fetchValid = 1'b1; fetchWord = W0; issueReady = 1'b1;
    step();
    fetchWord = W1; issueReady = 1'b0;
    step();
    chk("prerst iv", 32'(issueValid), 32'd1);
    fetchValid = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("arst iv", 32'(issueValid), 32'd0);
    chk("arst cm", 32'(cntMulti), 32'd0);
    chk("arst fr", 32'(fetchReady), 32'd0);
    chk("arst chkA", chkWordA, 32'd0);
    chk("arst A", issueWordA, 32'd0);
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    fetchValid = 1'b1; fetchWord = W1; issueReady = 1'b1;
    step();
    chk("rel1 iv", 32'(issueValid), 32'd0);
    chk("rel1 chkA", chkWordA, W1);
    fetchValid = 1'b0;
    step();
    chk("rel2 iv", 32'(issueValid), 32'd1);
    chk("rel2 A", issueWordA, W1);
    chk("rel2 cm", 32'(cntMulti), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
